// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, payload width, default bit period.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int DATA_BITS          = 7;
    localparam int DEFAULT_BIT_CYCLES = 8;

endpackage

// File: rtl/hamming74_encoder.sv
// Combinational Hamming(7,4) encoder, codeword layout {d3,d2,d1,p4,d0,p2,p1}.
// Only instantiated by uart_hamming_tx when HAMMING_ENCODE_EN is defined.
module hamming74_encoder (
    input  logic [3:0] d,
    output logic [6:0] c
);

    logic p1;
    logic p2;
    logic p4;

    assign p1 = d[0] ^ d[1] ^ d[3];
    assign p2 = d[0] ^ d[2] ^ d[3];
    assign p4 = d[1] ^ d[2] ^ d[3];
    assign c  = {d[3], d[2], d[1], p4, d[0], p2, p1};

endmodule

// File: rtl/uart_hamming_tx.sv
// UART transmitter (start, 7 data bits LSB first, stop) with a one-entry holding buffer.
// Define HAMMING_ENCODE_EN to encode data_in[3:0] as a Hamming(7,4) codeword; otherwise data_in is sent as-is.
module uart_hamming_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy,
    output logic [1:0]           state_out,
    output logic                 frame_done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] codeword;

`ifdef HAMMING_ENCODE_EN
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[6:4];

    hamming74_encoder u_encoder (
        .d (data_in[3:0]),
        .c (codeword)
    );
`else
    assign codeword = data_in;
`endif

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 tx_q, tx_d;
    logic                 accept;
    logic                 drain;
    logic                 cnt_last;

    assign ready_out  = ena && !buf_full_q;
    assign accept     = valid_in && ready_out;
    assign cnt_last   = (cnt_q == CNT_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign state_out  = state_q;
    assign frame_done = ena && (state_q == STOP) && cnt_last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_d       = tx_q;
        drain      = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (buf_full_q) begin
                        shreg_d = buf_q;
                        drain   = 1'b1;
                        tx_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        tx_d    = shreg_q[0];
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (bit_q == BIT_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q >> 1;
                            tx_d    = shreg_q[1];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        // A queued word chains straight into the next start bit.
                        if (buf_full_q) begin
                            shreg_d = buf_q;
                            drain   = 1'b1;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (drain) begin
                buf_full_d = 1'b0;
            end
            if (accept) begin
                buf_d      = codeword;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
        end
        shreg_q <= shreg_d;
        buf_q   <= buf_d;
    end

endmodule

// File: doc/uart_hamming_tx.md
# uart_hamming_tx

UART transmitter that serialises 7-bit Hamming(7,4) codewords onto a single line in the same frame format our UART receiver consumes: one low start bit, 7 data bits LSB first, one high stop bit, each bit held for `BIT_CYCLES` enabled clocks. It sits between the data source and the `rx` pin of the far end. A one-entry holding buffer with a valid/ready handshake lets a second word be queued while a frame is on the line, so consecutive frames go out back-to-back.

## Interface
- `BIT_CYCLES`, 8: enabled clocks per bit; must equal the receiver's oversampling count; legal range ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  clock enable; when low, all state is frozen.
- `data_in`  in  7  payload; see Configuration for which bits are used.
- `valid_in`  in  1  source presents `data_in`.
- `ready_out`  out  1  holding buffer can accept a word.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  FSM not in IDLE.
- `state_out`  out  2  current FSM state.
- `frame_done`  out  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `state_out`=IDLE, `frame_done`=0, buffer empty (`ready_out`=1 if `ena`), all counters 0.
- States: IDLE=00, START=01, DATA=10, STOP=11. Unused encodings do not exist.
- Handshake: a word is accepted on a rising edge with `ena && valid_in && ready_out`. `ready_out` = `ena && !buf_full`. There is no pass-through: the word is always captured into the buffer first.
- The buffer holds the already-encoded 7-bit codeword.
- IDLE: when `buf_full`, load the shift register from the buffer, clear `buf_full`, set `tx`=0, and go to START.
- START: hold `tx`=0 for `BIT_CYCLES` clocks, then go to DATA with `tx`=codeword bit 0.
- DATA: each bit is held `BIT_CYCLES` clocks. Bit counter runs 0..6 and the register shifts right. After bit 6, go to STOP with `tx`=1.
- STOP: hold `tx`=1 for `BIT_CYCLES` clocks. On the final clock, pulse `frame_done`, then:
  - if `buf_full`: go directly to START (`tx`=0), with no idle gap;
  - otherwise go to IDLE.
- A new word may be accepted during any state, including on the same edge the buffer drains into the shift register.
- `ena` low: counters, state, buffer and `tx` hold; `frame_done` is forced 0; the handshake is ignored.
- `rst` mid-frame: the frame is abandoned. `tx`=1 from the next edge, and the buffered word is discarded.
- The sample counter is `$clog2(BIT_CYCLES)` bits wide and wraps to 0 at `BIT_CYCLES-1`.

## Timing
- Accept at edge E0 → `tx` falls at E1 (when IDLE), giving 1-cycle latency.
- Frame length is exactly `9*BIT_CYCLES` enabled clocks (72 by default), measured from the `tx` falling edge to the next start bit or to the return to IDLE.
- `frame_done` is high during the 72nd clock of the frame.
- Sustained throughput is one frame per `9*BIT_CYCLES` cycles when `valid_in` is held high.

## Configuration
- `HAMMING_ENCODE_EN` defined:
  - `data_in[3:0]` = d0..d3 is encoded, and `data_in[6:4]` is ignored.
  - Parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
  - Codeword c[6:0] = {d3,d2,d1,p4,d0,p2,p1}.
- `HAMMING_ENCODE_EN` undefined: `data_in[6:0]` is transmitted unmodified and the encoder is not instantiated.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams IDLE/START/DATA/STOP, shared with the receiver;
  - `DATA_BITS`=7;
  - default `BIT_CYCLES`=8.
- One sub-module `hamming74_encoder`: combinational, 4 bits in, 7 bits out. It is instantiated only under `HAMMING_ENCODE_EN` and is reusable by tests as a reference model.

## Test plan
- Reset: hold `rst` for 2 cycles with `ena`=1 → `tx`=1, `ready_out`=1, `busy`=0, `state_out`=00, `frame_done`=0.
- Single frame, macro on, `data_in`=4'b1011:
  - codeword 7'b1010101;
  - `tx` = 0 (×8), then 1,0,1,0,1,0,1 (×8 each), then 1 (×8);
  - `frame_done` at clock 72; IDLE after.
- Back-to-back: present 4'h3 then 4'hC with `valid_in` held → second start bit begins on the clock after the first `frame_done`, with no idle cycle; `ready_out` low while the buffer is full.
- `ena` low for 5 cycles in the middle of data bit 3 → bit 3 lasts 13 clocks, all other bits last 8, and the sequence is otherwise unchanged.
- `rst` pulse during data bit 4 with a word buffered → `tx`=1 next edge, IDLE, `ready_out`=1, and no frame is emitted afterwards.
- Loopback into the UART receiver, macro off, `data_in`=7'h55 → receiver `data_out`=7'h55 with `valid_out`=1 during its stop bit.
